alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational `alu` instance between `NREQ` requesters, for example the execute stage and an address/branch helper. It arbitrates round-robin over valid/ready request channels and drives the selected operands and opcode onto the ALU. It captures the ALU result in a register and returns it to the winning requester over a valid/ready response channel. At most one response is outstanding at any time. A new request is accepted in the same cycle the held response is consumed, so throughput is one operation per cycle.

## Interface

Parameters:
- `NREQ`, 2: number of requesters, ≥ 2.
- `OPW`, 5: ALU opcode width; matches `ALUOP_WIDTH`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, NREQ: bit i means requester i presents an operation.
- `req_ready`, out, NREQ: bit i means requester i's operation is accepted this cycle.
- `req_a`, in, 64*NREQ: operand A; slice i is `[64*i+63:64*i]`.
- `req_b`, in, 64*NREQ: operand B, sliced the same way.
- `req_op`, in, OPW*NREQ: ALU opcode; slice i is `[OPW*i+OPW-1:OPW*i]`.
- `resp_valid`, out, NREQ: one-hot; bit i means the held result belongs to requester i.
- `resp_data`, out, 64: held result.
- `resp_ready`, in, NREQ: bit i means requester i consumes the response.
- `alu_a`, out, 64: operand A to the ALU.
- `alu_b`, out, 64: operand B to the ALU.
- `alu_op`, out, OPW: opcode to the ALU.
- `alu_data`, in, 64: combinational ALU result.

## Operation

- State is `IDLE` (no held response) or `HOLD` (response held for `owner`).
- Registers: `state`, `owner` (index), `rr_ptr` (index), `resp_data`.
- `can_accept = (state==IDLE) | (state==HOLD & resp_ready[owner])`.
- `grant`: the first i with `req_valid[i]`, searching from `rr_ptr` upward and wrapping modulo NREQ. If no request is valid, there is no grant.
- `req_ready[i] = can_accept & grant==i`. At most one bit is high. `req_ready` depends on `req_valid` and `resp_ready` but never on the operands.
- `alu_a`/`alu_b`/`alu_op` carry the granted requester's slices whenever a grant exists, even if `can_accept` is 0. With no grant they are all zero.
- Accept happens when `req_valid[g] & req_ready[g]`. On accept:
  - `resp_data <= alu_data`
  - `owner <= g`
  - `state <= HOLD`
  - `rr_ptr <= (g+1) mod NREQ`
- In `HOLD`, `resp_ready[owner]` is high, and nothing is accepted: `state <= IDLE`.
- `resp_ready` bits of non-owners are ignored.
- `resp_valid[i] = (state==HOLD) & owner==i`.
- Requester obligations: once `req_valid` is asserted, operands stay stable until accepted. Dropping `req_valid` before acceptance is legal, and that requester is simply not granted.
- Opcode values pass through unmodified; the arbiter does not interpret or check them.

## Timing

- Reset values:
  - `state=IDLE`, `owner=0`, `rr_ptr=0`, `resp_data=0`
  - `resp_valid=0`
  - `req_ready` reflects only `req_valid`, because the block is `IDLE`.
- Latency: a request accepted at edge N presents its response at N+1. Minimum request-to-response is 1 cycle.
- Throughput: 1 op/cycle with continuous `resp_ready`. Each consuming cycle accepts the next request.
- Backpressure: `resp_valid` and `resp_data` hold stable until the owner's `resp_ready`. No new accept happens while the owner withholds `resp_ready`.
- Simultaneous valids: the grant follows `rr_ptr`. A requester that stays valid waits at most NREQ-1 accepts.
- Simultaneous consume and accept of the same requester is legal. `resp_valid` stays high with the new data.
- `rr_ptr` wraps from NREQ-1 to 0.
- `rr_ptr` advances only on accept, never on a grant without `can_accept`.
- Reset during `HOLD`: the held response is discarded. Outputs return to reset values asynchronously.

## Test plan

- Single request, no contention: req0 with A=5, B=3, op=0 while `resp_ready` is held high. `req_ready[0]` is high in cycle 0. In cycle 1, `resp_valid=01` and `resp_data=8`.
- Simultaneous requests after reset: req0 (A=10, B=4, op=1) and req1 (A=1, B=4, op=7) are both valid and `resp_ready=11`. Cycle 0 accepts req0. In cycle 1, `resp_data=6` for owner 0 and req1 is accepted. In cycle 2, `resp_data=16` for owner 1.
- Backpressure: req1 with A=-1, B=1, op=5 is accepted. `resp_ready[1]=0` for 3 cycles. `resp_valid=10` and `resp_data=1` stay stable. A valid req0 is not accepted until `resp_ready[1]` rises, and is accepted in that same cycle.
- Round-robin wrap: both requesters are valid continuously for 6 accepts. Grant order is 0,1,0,1,0,1.
- Non-owner `resp_ready`: the owner is 0, `resp_ready=10`, and req1 is valid. The response stays held and req1 is not accepted.
- Reset mid-`HOLD`: assert `reset` asynchronously while `resp_valid=01`. `resp_valid` goes to 0 immediately. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ valid/ready requesters,
// holding a single registered result until its owner consumes it.
module alu_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned OPW  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    input  logic [OPW*NREQ-1:0]  req_op,
    output logic [NREQ-1:0]      resp_valid,
    output logic [63:0]          resp_data,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [63:0]          alu_a,
    output logic [63:0]          alu_b,
    output logic [OPW-1:0]       alu_op,
    input  logic [63:0]          alu_data
);

    localparam int unsigned DW = 64;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]   resp_data_q, resp_data_d;

    logic            grant_vld_c;
    logic [IW-1:0]   grant_idx_c;
    logic [IW-1:0]   cand_c;
    logic            can_accept_c;
    logic            accept_c;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_c = IW'((32'(rr_ptr_q) + k) % NREQ);
            if (!grant_vld_c && req_valid[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand_c;
            end
        end
    end

    always_comb begin
        can_accept_c = (state_q == IDLE) || ((state_q == HOLD) && resp_ready[owner_q]);
        accept_c     = can_accept_c && grant_vld_c;
    end

    // Granted operands reach the ALU even while blocked, so req_ready never depends on them.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (grant_vld_c) begin
            alu_a  = req_a[DW*32'(grant_idx_c) +: DW];
            alu_b  = req_b[DW*32'(grant_idx_c) +: DW];
            alu_op = req_op[OPW*32'(grant_idx_c) +: OPW];
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept_c) begin
            req_ready[grant_idx_c] = 1'b1;
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            resp_valid[i] = (state_q == HOLD) && (owner_q == IW'(i));
        end
    end

    assign resp_data = resp_data_q;

    // Consuming and accepting in the same cycle keeps HOLD with the new result.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        resp_data_d = resp_data_q;
        case (state_q)
            IDLE: state_d = IDLE;
            HOLD: if (resp_ready[owner_q]) state_d = IDLE;
        endcase
        if (accept_c) begin
            state_d     = HOLD;
            owner_d     = grant_idx_c;
            rr_ptr_d    = (grant_idx_c == IW'(NREQ-1)) ? '0 : grant_idx_c + IW'(1);
            resp_data_d = alu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_data_q <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a small reference ALU drives alu_data, and a scoreboard checks
// every held response against results predicted when each request is accepted.
module tb_alu_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned OPW  = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [64*NREQ-1:0]   req_a;
    logic [64*NREQ-1:0]   req_b;
    logic [OPW*NREQ-1:0]  req_op;
    logic [NREQ-1:0]      resp_valid;
    logic [63:0]          resp_data;
    logic [NREQ-1:0]      resp_ready;
    logic [63:0]          alu_a;
    logic [63:0]          alu_b;
    logic [OPW-1:0]       alu_op;
    logic [63:0]          alu_data;

    typedef struct {
        int unsigned owner;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [63:0]    ta  [NREQ];
    logic [63:0]    tb  [NREQ];
    logic [OPW-1:0] top [NREQ];
    logic [OPW-1:0] ops [4];

    alu_arbiter #(.NREQ(NREQ), .OPW(OPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_data   (alu_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [OPW-1:0] op);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd5:    return a & b;
            5'd7:    return a << b[5:0];
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_data = alu_f(alu_a, alu_b, alu_op);

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [OPW-1:0] op);
        req_a[64*i +: 64]   = a;
        req_b[64*i +: 64]   = b;
        req_op[OPW*i +: OPW] = op;
        ta[i]  = a;
        tb[i]  = b;
        top[i] = op;
    endtask

    task automatic push_exp(input int unsigned owner, input logic [63:0] data);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard: each held response must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!reset && resp_valid != '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: resp_valid=%b resp_data=%h, required no response", resp_valid, resp_data);
            end else begin
                if (resp_valid !== (NREQ'(1) << exp_q[0].owner) || resp_data !== exp_q[0].data) begin
                    n_bad++;
                    $display("FAIL sb_resp: resp_valid=%b resp_data=%h, required valid=%b data=%h",
                             resp_valid, resp_data, NREQ'(1) << exp_q[0].owner, exp_q[0].data);
                end
                if ((resp_valid & resp_ready) != '0) void'(exp_q.pop_front());
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; resp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        #3;
        n_cmp++; if (resp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_resp_valid: got %b, required 00", resp_valid); end
        n_cmp++; if (resp_data !== 64'd0) begin n_bad++; $display("FAIL rst_resp_data: got %h, required 0", resp_data); end
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready_idle: got %b, required 00", req_ready); end
        n_cmp++; if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_op !== 5'd0) begin
            n_bad++; $display("FAIL rst_alu_nogrant: got a=%h b=%h op=%h, required zeros", alu_a, alu_b, alu_op);
        end
        set_req(1, 64'd2, 64'd3, 5'd0);
        req_valid = 2'b10;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL rst_req_ready_valid: got %b, required 10", req_ready); end
        n_cmp++; if (alu_a !== 64'd2 || alu_b !== 64'd3) begin
            n_bad++; $display("FAIL rst_alu_route: got a=%h b=%h, required 2 3", alu_a, alu_b);
        end
        req_valid = '0;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_single();
        resp_ready = 2'b11;
        set_req(0, 64'd5, 64'd3, 5'd0);
        req_valid = 2'b01;
        @(negedge clk);
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b, required 01", req_ready); end
        push_exp(0, 64'd8);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 2'b01 || resp_data !== 64'd8) begin
            n_bad++; $display("FAIL single_resp: got valid=%b data=%h, required 01 8", resp_valid, resp_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 2'b00) begin n_bad++; $display("FAIL single_drain: got %b, required 00", resp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        reset = 1'b1; #2 reset = 1'b0;
        resp_ready = 2'b11;
        set_req(0, 64'd10, 64'd4, 5'd1);
        set_req(1, 64'd1, 64'd4, 5'd7);
        req_valid = 2'b11;
        @(negedge clk);
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL simul_first: got %b, required 01", req_ready); end
        push_exp(0, 64'd6);
        @(posedge clk); #1 req_valid = 2'b10;
        @(negedge clk);
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL simul_second: got %b, required 10", req_ready); end
        n_cmp++; if (resp_data !== 64'd6) begin n_bad++; $display("FAIL simul_data0: got %h, required 6", resp_data); end
        push_exp(1, 64'd16);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 2'b10 || resp_data !== 64'd16) begin
            n_bad++; $display("FAIL simul_data1: got valid=%b data=%h, required 10 10h", resp_valid, resp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        resp_ready = 2'b01;
        set_req(1, '1, 64'd1, 5'd5);
        req_valid = 2'b10;
        @(negedge clk);
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_accept: got %b, required 10", req_ready); end
        push_exp(1, 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            set_req(0, 64'd7, 64'd2, 5'd0);
            req_valid = 2'b01;
            @(negedge clk);
            n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL bp_blocked[%0d]: got %b, required 00", c, req_ready); end
            n_cmp++; if (resp_valid !== 2'b10 || resp_data !== 64'd1) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h, required 10 1", c, resp_valid, resp_data);
            end
        end
        @(posedge clk); #1 resp_ready = 2'b11;
        @(negedge clk);
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_release: got %b, required 01", req_ready); end
        push_exp(0, 64'd9);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 2'b01 || resp_data !== 64'd9) begin
            n_bad++; $display("FAIL bp_next: got valid=%b data=%h, required 01 9", resp_valid, resp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rr_wrap();
        reset = 1'b1; #2 reset = 1'b0;
        resp_ready = 2'b11;
        for (int i = 0; i < 2; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, ops[$urandom_range(0, 3)]);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 2;
            if (k > 0) begin
                @(posedge clk); #1;
                set_req((k - 1) % 2, {$urandom, $urandom}, {$urandom, $urandom}, ops[$urandom_range(0, 3)]);
            end
            @(negedge clk);
            n_cmp++; if (req_ready !== (2'b01 << g)) begin
                n_bad++; $display("FAIL rr_grant[%0d]: got %b, required %b", k, req_ready, 2'b01 << g);
            end
            push_exp(g, alu_f(ta[g], tb[g], top[g]));
        end
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_nonowner();
        resp_ready = 2'b11;
        set_req(0, 64'd100, 64'd23, 5'd1);
        req_valid = 2'b01;
        @(negedge clk);
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL nonown_accept: got %b, required 01", req_ready); end
        push_exp(0, 64'd77);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            resp_ready = 2'b10;
            set_req(1, 64'd3, 64'd4, 5'd0);
            req_valid = 2'b10;
            @(negedge clk);
            n_cmp++; if (req_ready !== 2'b00 || resp_valid !== 2'b01) begin
                n_bad++; $display("FAIL nonown_hold[%0d]: got ready=%b valid=%b, required 00 01", c, req_ready, resp_valid);
            end
        end
        @(posedge clk); #1 resp_ready = 2'b01;
        @(negedge clk);
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL nonown_release: got %b, required 10", req_ready); end
        push_exp(1, 64'd7);
        @(posedge clk); #1 req_valid = '0; resp_ready = 2'b11;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_hold();
        resp_ready = 2'b00;
        set_req(0, 64'd40, 64'd2, 5'd0);
        req_valid = 2'b01;
        @(negedge clk);
        push_exp(0, 64'd42);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 2'b01) begin n_bad++; $display("FAIL rh_held: got %b, required 01", resp_valid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (resp_valid !== 2'b00 || resp_data !== 64'd0) begin
            n_bad++; $display("FAIL rh_async: got valid=%b data=%h, required 00 0", resp_valid, resp_data);
        end
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        resp_ready = 2'b11;
        set_req(0, 64'd1, 64'd1, 5'd0);
        set_req(1, 64'd2, 64'd2, 5'd0);
        req_valid = 2'b11;
        @(negedge clk);
        n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rh_first_grant: got %b, required 01", req_ready); end
        push_exp(0, 64'd2);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        ops[0] = 5'd0; ops[1] = 5'd1; ops[2] = 5'd5; ops[3] = 5'd7;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_rr_wrap();
        test_nonowner();
        test_reset_hold();
        @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover: got %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
